// File: rtl/calc_demo_display.sv
// rtl/calc_demo_display.sv - 4-bit add/sub calculator with accumulate, demo counter and 4-digit seven-segment driver
module calc_demo_display #(
    parameter int unsigned DEMO_DIV    = 50_000_000,
    parameter int unsigned REFRESH_DIV = 100_000
) (
    input  logic       clk,
    input  logic       clr,
    input  logic [3:0] A,
    input  logic [3:0] B,
    input  logic       Sub,
    input  logic       RC,
    input  logic       en,
    input  logic       Demo,
    output logic [7:0] sseg,
    output logic [3:0] an
);

    localparam int unsigned DW = (DEMO_DIV > 1) ? $clog2(DEMO_DIV) : 1;
    localparam int unsigned RW = (REFRESH_DIV > 1) ? $clog2(REFRESH_DIV) : 1;
    localparam logic [DW-1:0] DEMO_MAX    = DW'(DEMO_DIV - 1);
    localparam logic [RW-1:0] REFRESH_MAX = RW'(REFRESH_DIV - 1);

    localparam logic [7:0] SEG_BLANK = 8'hFF;
    localparam logic [7:0] SEG_MINUS = 8'hBF;

    // Active-low segment code for one decimal digit (dp kept off)
    function automatic logic [7:0] seg7(input logic [3:0] d);
        logic [7:0] s;
        case (d)
            4'd0:    s = 8'hC0;
            4'd1:    s = 8'hF9;
            4'd2:    s = 8'hA4;
            4'd3:    s = 8'hB0;
            4'd4:    s = 8'h99;
            4'd5:    s = 8'h92;
            4'd6:    s = 8'h82;
            4'd7:    s = 8'hF8;
            4'd8:    s = 8'h80;
            4'd9:    s = 8'h90;
            default: s = SEG_BLANK;
        endcase
        return s;
    endfunction

    logic [DW-1:0] dpre_q, dpre_d;
    logic [7:0]    dcnt_q, dcnt_d;
    logic [RW-1:0] rpre_q, rpre_d;
    logic [1:0]    idx_q,  idx_d;
    logic [7:0]    r_q,    r_d;

    logic [3:0] op_a;
    logic [3:0] op_b;
    logic [7:0] base;
    logic [7:0] addend;

    logic       neg;
    logic [7:0] mag;
    logic       hund;
    logic [7:0] rem;
    logic [3:0] tens;
    logic [3:0] units;
    logic [7:0] dig3, dig2, dig1, dig0;

    // Demo counter: steps once per DEMO_DIV cycles while Demo is on, held cleared otherwise
    always_comb begin
        dpre_d = dpre_q;
        dcnt_d = dcnt_q;
        if (!Demo) begin
            dpre_d = '0;
            dcnt_d = '0;
        end else if (dpre_q == DEMO_MAX) begin
            dpre_d = '0;
            dcnt_d = dcnt_q + 8'd1;
        end else begin
            dpre_d = dpre_q + DW'(1);
        end
    end

    // Operand selection and next result: fresh opA +/- opB, or running R +/- opB
    always_comb begin
        op_a   = Demo ? dcnt_q[7:4] : A;
        op_b   = Demo ? dcnt_q[3:0] : B;
        base   = RC ? r_q : {4'b0000, op_a};
        addend = {4'b0000, op_b};
        r_d    = r_q;
        if (en) begin
            r_d = Sub ? (base - addend) : (base + addend);
        end
    end

    // Refresh prescaler and digit index rotation 0->1->2->3->0
    always_comb begin
        rpre_d = rpre_q + RW'(1);
        idx_d  = idx_q;
        if (rpre_q == REFRESH_MAX) begin
            rpre_d = '0;
            idx_d  = idx_q + 2'd1;
        end
    end

    // All state registers, asynchronously cleared
    always_ff @(posedge clk or posedge clr) begin
        if (clr) begin
            dpre_q <= '0;
            dcnt_q <= '0;
            rpre_q <= '0;
            idx_q  <= '0;
            r_q    <= '0;
        end else begin
            dpre_q <= dpre_d;
            dcnt_q <= dcnt_d;
            rpre_q <= rpre_d;
            idx_q  <= idx_d;
            r_q    <= r_d;
        end
    end

    // Sign + magnitude split of R into hundreds/tens/units; |R| never exceeds 128
    always_comb begin
        neg   = r_q[7];
        mag   = neg ? (8'd0 - r_q) : r_q;
        hund  = (mag >= 8'd100);
        rem   = hund ? (mag - 8'd100) : mag;
        tens  = 4'(rem / 8'd10);
        units = 4'(rem % 8'd10);
        dig3  = neg ? SEG_MINUS : SEG_BLANK;
        dig2  = hund ? seg7(4'd1) : SEG_BLANK;
        dig1  = (hund || (tens != 4'd0)) ? seg7(tens) : SEG_BLANK;
        dig0  = seg7(units);
    end

    // Digit multiplexer: one anode low at a time, segments follow the selected digit
    always_comb begin
        an = ~(4'b0001 << idx_q);
        case (idx_q)
            2'd0:    sseg = dig0;
            2'd1:    sseg = dig1;
            2'd2:    sseg = dig2;
            default: sseg = dig3;
        endcase
    end

endmodule

// File: tb/tb_calc_demo_display.sv
// tb/tb_calc_demo_display.sv - directed self-checking bench for calc_demo_display
module tb_calc_demo_display;

    logic       clk = 1'b0;
    logic       clr;
    logic [3:0] A;
    logic [3:0] B;
    logic       Sub;
    logic       RC;
    logic       en;
    logic       Demo;
    logic [7:0] sseg;
    logic [3:0] an;

    int total = 0;
    int bad   = 0;

    calc_demo_display #(
        .DEMO_DIV   (4),
        .REFRESH_DIV(2)
    ) dut (
        .clk (clk),
        .clr (clr),
        .A   (A),
        .B   (B),
        .Sub (Sub),
        .RC  (RC),
        .en  (en),
        .Demo(Demo),
        .sseg(sseg),
        .an  (an)
    );

    always #5 clk = ~clk;

    // Collect all four digit codes {an3,an2,an1,an0} over one full refresh rotation
    task automatic grab(output logic [31:0] d);
        d = 'x;
        for (int i = 0; i < 8; i++) begin
            case (an)
                4'b1110: d[7:0]   = sseg;
                4'b1101: d[15:8]  = sseg;
                4'b1011: d[23:16] = sseg;
                4'b0111: d[31:24] = sseg;
                default: ;
            endcase
            @(negedge clk);
        end
    endtask

    // Hold en high for exactly n rising edges, starting and ending on a falling edge
    task automatic step(input int n);
        en = 1'b1;
        repeat (n) @(negedge clk);
        en = 1'b0;
    endtask

    task automatic test_reset;
        logic [3:0] exp_an;
        logic [7:0] exp_seg;
        clr = 1'b1; A = 4'd0; B = 4'd0; Sub = 1'b0; RC = 1'b0; en = 1'b0; Demo = 1'b0;
        #12;
        total++;
        if (an !== 4'b1110) begin bad++; $display("FAIL reset_an got=%b exp=%b", an, 4'b1110); end
        total++;
        if (sseg !== 8'hC0) begin bad++; $display("FAIL reset_sseg got=%h exp=%h", sseg, 8'hC0); end
        @(negedge clk);
        clr = 1'b0;
        for (int k = 0; k < 8; k++) begin
            exp_an  = ~(4'b0001 << (k / 2));
            exp_seg = (k < 2) ? 8'hC0 : 8'hFF;
            total++;
            if (an !== exp_an) begin bad++; $display("FAIL reset_walk_an k=%0d got=%b exp=%b", k, an, exp_an); end
            total++;
            if (sseg !== exp_seg) begin bad++; $display("FAIL reset_walk_sseg k=%0d got=%h exp=%h", k, sseg, exp_seg); end
            @(negedge clk);
        end
    endtask

    task automatic test_add;
        logic [31:0] d;
        A = 4'd3; B = 4'd2; Sub = 1'b0; RC = 1'b0;
        step(1);
        grab(d);
        total++;
        if (d !== 32'hFFFFFF92) begin bad++; $display("FAIL add_3p2 got=%h exp=%h", d, 32'hFFFFFF92); end
    endtask

    task automatic test_sub;
        logic [31:0] d;
        A = 4'd2; B = 4'd3; Sub = 1'b1; RC = 1'b0;
        step(1);
        grab(d);
        total++;
        if (d !== 32'hBFFFFFF9) begin bad++; $display("FAIL sub_m1 got=%h exp=%h", d, 32'hBFFFFFF9); end
        A = 4'd0; B = 4'd15;
        step(1);
        grab(d);
        total++;
        if (d !== 32'hBFFFF992) begin bad++; $display("FAIL sub_m15 got=%h exp=%h", d, 32'hBFFFF992); end
    endtask

    task automatic test_accumulate;
        logic [31:0] d;
        logic [31:0] exp_tab [7];
        logic        sub_tab [7];
        // 122, 124, 126, -128, -126, then subtracting: -128, 126 (wrap)
        exp_tab = '{32'hFFF9A4A4, 32'hFFF9A499, 32'hFFF9A482, 32'hBFF9A480,
                    32'hBFF9A482, 32'hBFF9A480, 32'hFFF9A482};
        sub_tab = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1};
        A = 4'd0; B = 4'd0; Sub = 1'b0; RC = 1'b0;
        step(1);
        RC = 1'b1; B = 4'd15;
        step(8);
        grab(d);
        total++;
        if (d !== 32'hFFF9A4C0) begin bad++; $display("FAIL acc_preload_120 got=%h exp=%h", d, 32'hFFF9A4C0); end
        B = 4'd2;
        for (int i = 0; i < 7; i++) begin
            Sub = sub_tab[i];
            step(1);
            grab(d);
            total++;
            if (d !== exp_tab[i]) begin bad++; $display("FAIL acc_step%0d got=%h exp=%h", i, d, exp_tab[i]); end
        end
        Sub = 1'b0; B = 4'd9;
        repeat (5) @(negedge clk);
        grab(d);
        total++;
        if (d !== 32'hFFF9A482) begin bad++; $display("FAIL acc_hold got=%h exp=%h", d, 32'hFFF9A482); end
    endtask

    task automatic test_demo;
        logic [31:0] d;
        RC = 1'b0; Sub = 1'b0; A = 4'd9; B = 4'd9;
        Demo = 1'b1;
        repeat (3) @(negedge clk);
        step(1);
        grab(d);
        total++;
        if (d !== 32'hFFFFFFC0) begin bad++; $display("FAIL demo_before_step got=%h exp=%h", d, 32'hFFFFFFC0); end
        Demo = 1'b0;
        @(negedge clk);
        Demo = 1'b1;
        repeat (4) @(negedge clk);
        step(1);
        grab(d);
        total++;
        if (d !== 32'hFFFFFFF9) begin bad++; $display("FAIL demo_first_step got=%h exp=%h", d, 32'hFFFFFFF9); end
        Demo = 1'b0;
        @(negedge clk);
        Demo = 1'b1;
        step(142);
        grab(d);
        total++;
        if (d !== 32'hFFFFFF92) begin bad++; $display("FAIL demo_dcnt23 got=%h exp=%h", d, 32'hFFFFFF92); end
        A = 4'd7; B = 4'd1; Demo = 1'b0;
        step(1);
        grab(d);
        total++;
        if (d !== 32'hFFFFFF80) begin bad++; $display("FAIL demo_revert got=%h exp=%h", d, 32'hFFFFFF80); end
    endtask

    task automatic test_midreset;
        logic [31:0] d;
        RC = 1'b1; Sub = 1'b0; B = 4'd5;
        en = 1'b1;
        repeat (3) @(negedge clk);
        @(posedge clk);
        #2;
        clr = 1'b1;
        #1;
        total++;
        if (an !== 4'b1110) begin bad++; $display("FAIL midreset_an got=%b exp=%b", an, 4'b1110); end
        total++;
        if (sseg !== 8'hC0) begin bad++; $display("FAIL midreset_sseg got=%h exp=%h", sseg, 8'hC0); end
        @(negedge clk);
        clr = 1'b0;
        en  = 1'b0;
        step(1);
        grab(d);
        total++;
        if (d !== 32'hFFFFFF92) begin bad++; $display("FAIL midreset_resume got=%h exp=%h", d, 32'hFFFFFF92); end
    endtask

    initial begin
        test_reset();
        test_add();
        test_sub();
        test_accumulate();
        test_demo();
        test_midreset();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
